// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL lock qualification, retry and ordered domain reset release
module pll_reset_sequencer #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 2500000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP_CYCLES    = 64,
    parameter int CNT_W               = 22
) (
    input  logic       clki,
    input  logic       reset,
    input  logic       locked_i,
    output logic       pll_reset_o,
    output logic       rst_shift_o,
    output logic       rst_pixel_o,
    output logic       rst_cpu_o,
    output logic       ready_o,
    output logic [7:0] lock_loss_count_o,
    output logic [7:0] retry_count_o,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        REL_SHIFT = 3'd3,
        REL_PIXEL = 3'd4,
        RUN       = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_N     = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [7:0]             loss_q, loss_d, retry_q, retry_d;
    logic                   pll_rst_q, shift_q, pixel_q, cpu_q, ready_q;
    logic                   lost;

    assign locked_s = sync_q[SYNC_STAGES-1];
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // Bring the asynchronous lock flag into clki through a flop chain
    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= locked_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Sequencer next state, shared counter and saturating event counts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        loss_d  = loss_q;
        retry_d = retry_q;
        lost    = 1'b0;
        case (state_q)
            PLL_RST: if (cnt_q >= PLL_LAST) begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
            WAIT_LOCK: if (locked_s) begin
                state_d = STABLE;
                cnt_d   = CNT_W'(1);
            end else if (cnt_q >= TIMEOUT_LAST) begin
                state_d = PLL_RST;
                cnt_d   = '0;
                retry_d = (&retry_q) ? retry_q : retry_q + 8'd1;
            end
            STABLE: if (!locked_s) begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end else if (cnt_q >= STABLE_N) begin
                state_d = REL_SHIFT;
                cnt_d   = '0;
            end
            REL_SHIFT: if (!locked_s) begin
                lost = 1'b1;
            end else if (cnt_q >= GAP_LAST) begin
                state_d = REL_PIXEL;
                cnt_d   = '0;
            end
            REL_PIXEL: if (!locked_s) begin
                lost = 1'b1;
            end else if (cnt_q >= GAP_LAST) begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: lost = !locked_s;
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
        if (lost) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            loss_d  = (&loss_q) ? loss_q : loss_q + 8'd1;
        end
    end

    // Register state and derive every output from the state being entered
    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            loss_q    <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            shift_q   <= 1'b1;
            pixel_q   <= 1'b1;
            cpu_q     <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            retry_q   <= retry_d;
            pll_rst_q <= state_d == PLL_RST;
            shift_q   <= !(state_d == REL_SHIFT || state_d == REL_PIXEL || state_d == RUN);
            pixel_q   <= !(state_d == REL_PIXEL || state_d == RUN);
            cpu_q     <= state_d != RUN;
            ready_q   <= state_d == RUN;
        end
    end

    assign pll_reset_o       = pll_rst_q;
    assign rst_shift_o       = shift_q;
    assign rst_pixel_o       = pixel_q;
    assign rst_cpu_o         = cpu_q;
    assign ready_o           = ready_q;
    assign lock_loss_count_o = loss_q;
    assign retry_count_o     = retry_q;
    assign state_o           = state_q;
endmodule
